conv_out_requant: RTL and testbench

Sits directly downstream of the convolution layer. It consumes the per-tree 32-bit window sums and tracks the raster position of the pixel stream feeding the convolution. It masks sums from partially filled windows (fill and row wrap), requantizes each valid sum to 8 bits, and emits a valid-qualified pixel stream plus end-of-frame pulse for the next layer (pooling or the next convolution).

---
 rtl/conv_out_requant.sv | 181 ++++++++++++++++++
 tb/tb_conv_out_requant.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_requant.sv
// Masks and requantizes convolution window sums into an 8-bit, valid-qualified pixel stream.
// Optional build macro CONV_REQUANT_RELU_EN selects unsigned ReLU clamping instead of signed saturation.
//
// state  | meaning
// S_IDLE | between frames; the next pixel_valid_in starts a frame at col 0, row 0
// S_RUN  | inside a frame; every cycle must carry a pixel
// S_ERR  | the stream broke mid-frame; sticky until reset

module conv_out_requant #(
  parameter int NUM_TREES  = 4,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int KERNEL_W   = 5,
  parameter int KERNEL_H   = 5,
  parameter int MA_LATENCY = 4,
  parameter int SHIFT      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pixel_valid_in,
  input  logic [32*NUM_TREES-1:0] sum_in,
  output logic [8*NUM_TREES-1:0]  pixel_out,
  output logic                   valid_out,
  output logic                   frame_done,
  output logic                   stream_error
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_WIN = COL_W'(KERNEL_W - 1);
  localparam logic [ROW_W-1:0] ROW_WIN = ROW_W'(KERNEL_H - 1);

  localparam logic signed [32:0] ROUND = 33'(2 ** (SHIFT - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic             accept;
  logic             at_last;
  logic             win_ok;
  logic             win_last;

  logic [MA_LATENCY-1:0] win_dly;
  logic [MA_LATENCY-1:0] last_dly;
  logic                  win_aligned;
  logic                  last_aligned;

  logic [8*NUM_TREES-1:0] requant;

  always_comb begin
    accept   = pixel_valid_in && (state != S_ERR);
    at_last  = (col == COL_MAX) && (row == ROW_MAX);
    win_ok   = accept && (col >= COL_WIN) && (row >= ROW_WIN);
    win_last = win_ok && at_last;
    col_nxt  = col + COL_W'(1);
    row_nxt  = row;
    if (col == COL_MAX) begin
      col_nxt = '0;
      row_nxt = (row == ROW_MAX) ? '0 : row + ROW_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      col          <= '0;
      row          <= '0;
      stream_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pixel_valid_in) begin
            col   <= col_nxt;
            row   <= row_nxt;
            state <= at_last ? S_IDLE : S_RUN;
          end
        end
        S_RUN: begin
          if (pixel_valid_in) begin
            col <= col_nxt;
            row <= row_nxt;
            if (at_last) begin
              state <= S_IDLE;
            end
          end else begin
            // The convolution window is now corrupt; no way to resync mid-frame.
            state        <= S_ERR;
            stream_error <= 1'b1;
            col          <= '0;
            row          <= '0;
          end
        end
        S_ERR: begin
          col          <= '0;
          row          <= '0;
          stream_error <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          col   <= '0;
          row   <= '0;
        end
      endcase
    end
  end

  // Keeps shifting in every state so results of a finished frame drain even
  // when a new frame or an error follows immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_dly  <= '0;
      last_dly <= '0;
    end else begin
      win_dly[0]  <= win_ok;
      last_dly[0] <= win_last;
      for (int i = 1; i < MA_LATENCY; i++) begin
        win_dly[i]  <= win_dly[i-1];
        last_dly[i] <= last_dly[i-1];
      end
    end
  end

  assign win_aligned  = win_dly[MA_LATENCY-1];
  assign last_aligned = last_dly[MA_LATENCY-1];

  for (genvar g = 0; g < NUM_TREES; g++) begin : g_tree
    logic signed [32:0] rounded;
    logic signed [32:0] scaled;
    logic [7:0]         clamped;

    always_comb begin
      rounded = $signed({sum_in[32*g+31], sum_in[32*g +: 32]}) + ROUND;
      scaled  = rounded >>> SHIFT;
`ifdef CONV_REQUANT_RELU_EN
      if (scaled < 33'sd0) begin
        clamped = 8'h00;
      end else if (scaled > 33'sd255) begin
        clamped = 8'hFF;
      end else begin
        clamped = scaled[7:0];
      end
`else
      if (scaled < -33'sd128) begin
        clamped = 8'h80;
      end else if (scaled > 33'sd127) begin
        clamped = 8'h7F;
      end else begin
        clamped = scaled[7:0];
      end
`endif
    end

    assign requant[8*g +: 8] = clamped;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_out  <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= win_aligned;
      frame_done <= last_aligned;
      if (win_aligned) begin
        pixel_out <= requant;
      end
    end
  end

endmodule

// File: tb/tb_conv_out_requant.sv
// Scoreboard bench for conv_out_requant: directed frames, stream breaks and mid-frame reset.
// Expected pixels follow CONV_REQUANT_RELU_EN when the bench is built with it.

module tb_conv_out_requant;

  localparam int NT = 2;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int KW = 3;
  localparam int KH = 3;
  localparam int ML = 2;
  localparam int SH = 8;
  localparam logic [63:0] JUNK = 64'h0BAD_F00D_7FFF_0000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          pixel_valid_in = 1'b0;
  logic [63:0]   sum_in = '0;
  logic [15:0]   pixel_out;
  logic          valid_out;
  logic          frame_done;
  logic          stream_error;

  conv_out_requant #(
    .NUM_TREES (NT),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .KERNEL_W  (KW),
    .KERNEL_H  (KH),
    .MA_LATENCY(ML),
    .SHIFT     (SH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pixel_valid_in(pixel_valid_in),
    .sum_in        (sum_in),
    .pixel_out     (pixel_out),
    .valid_out     (valid_out),
    .frame_done    (frame_done),
    .stream_error  (stream_error)
  );

  always #5 clock = ~clock;

  int tick = 0;
  always @(posedge clock) tick <= tick + 1;

  // Hand-computed requantization vectors: round half up, then clamp.
  logic [31:0] vec_sum [0:11] = '{
    32'h0000_0180, 32'hFFFF_F000, 32'h0001_0000, 32'hFFFF_FF80,
    32'hFFFF_0000, 32'h0000_7F00, 32'h0000_0080, 32'hFFFF_FF7F,
    32'h0000_C800, 32'hFFFF_8100, 32'h8000_0000, 32'h7FFF_FFFF
  };
`ifdef CONV_REQUANT_RELU_EN
  logic [7:0] vec_exp [0:11] = '{
    8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h7F,
    8'h01, 8'h00, 8'hC8, 8'h00, 8'h00, 8'hFF
  };
`else
  logic [7:0] vec_exp [0:11] = '{
    8'h02, 8'hF0, 8'h7F, 8'h00, 8'h80, 8'h7F,
    8'h01, 8'hFF, 8'h7F, 8'h81, 8'h80, 8'h7F
  };
`endif

  typedef struct {
    logic [15:0] pix;
    logic        done;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [63:0] sum_at [0:2047];
  int          checks = 0;
  int          errors = 0;
  int          pos = 0;
  int          k = 0;
  bit          model_err = 1'b0;
  logic [15:0] last_pix = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at tick %0d", name, act, exp, tick);
    end
  endtask

  // One clock of stimulus; sum_in carries the sum for the pixel sent ML cycles earlier.
  task automatic step(input logic pv);
    logic [63:0] s;
    exp_t        e;
    int          r;
    int          c;
    s = JUNK;
    if (pv && !model_err) begin
      r = pos / W;
      c = pos % W;
      if (r >= KH - 1 && c >= KW - 1) begin
        s      = {vec_sum[(k + 5) % 12], vec_sum[k % 12]};
        e.pix  = {vec_exp[(k + 5) % 12], vec_exp[k % 12]};
        e.done = (pos == W * H - 1);
        e.t    = tick + ML + 1;
        q.push_back(e);
        k++;
      end
      pos = (pos + 1) % (W * H);
    end else if (!pv && pos != 0) begin
      model_err = 1'b1;
    end
    sum_at[tick % 2048] = s;
    sum_in = (tick >= ML) ? sum_at[(tick - ML) % 2048] : '0;
    pixel_valid_in = pv;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_pixel_out", 32'(pixel_out), 32'h0);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_stream_error", 32'(stream_error), 32'h0);
    pos = 0;
    model_err = 1'b0;
    q.delete();
    repeat (2) step(1'b0);
    reset = 1'b0;
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        last_pix = '0;
      end else if (valid_out) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'(valid_out), 32'h0);
        end else begin
          e = q.pop_front();
          chk("pixel_out", 32'(pixel_out), 32'(e.pix));
          chk("frame_done", 32'(frame_done), 32'(e.done));
          chk("latency_tick", 32'(tick), 32'(e.t));
        end
        last_pix = pixel_out;
      end else begin
        chk("frame_done_idle", 32'(frame_done), 32'h0);
        chk("pixel_hold", 32'(pixel_out), 32'(last_pix));
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 2048; i++) sum_at[i] = '0;
    #2;
    apply_reset();

    // single frame, then a gap in IDLE
    pixels(16);
    idle(6);

    // two frames back to back
    pixels(32);
    idle(6);
    chk("b2b_stream_error", 32'(stream_error), 32'h0);

    // stream breaks at pixel 6, before any full window
    pixels(5);
    chk("pre_break_error", 32'(stream_error), 32'h0);
    step(1'b0);
    chk("break6_error", 32'(stream_error), 32'h1);
    pixels(16);
    chk("break6_sticky", 32'(stream_error), 32'h1);
    apply_reset();

    // stream breaks at pixel 12 with pixel 11's result still in flight
    pixels(11);
    step(1'b0);
    chk("break12_error", 32'(stream_error), 32'h1);
    pixels(10);
    chk("break12_sticky", 32'(stream_error), 32'h1);
    apply_reset();

    // reset lands on pixel 9, then a fresh frame
    pixels(8);
    apply_reset();
    pixels(16);
    idle(6);
    chk("final_stream_error", 32'(stream_error), 32'h0);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
